// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM state encoding and default widths/reset PC.
package cpu_pkg;

   typedef enum logic {
      RUN  = 1'b0,
      HALT = 1'b1
   } state_e;

   localparam int CPU_ADDR_W   = 6;
   localparam int CPU_DATA_W   = 32;
   localparam int CPU_RESET_PC = 0;

endpackage

// File: rtl/ifetch_ctrl_if.sv
// Bus bundle between the fetch controller, the instruction ROM and decode.
// The debug read port exists only when IFETCH_DEBUG_PORT_EN is defined.
interface ifetch_ctrl_if
   import cpu_pkg::*;
#(
   parameter int ADDR_W = CPU_ADDR_W,
   parameter int DATA_W = CPU_DATA_W
);

   logic [ADDR_W-1:0] rom_addr;
   logic [DATA_W-1:0] rom_data;
   logic              if_valid;
   logic              if_ready;
   logic [DATA_W-1:0] if_instr;
   logic [ADDR_W-1:0] if_pc;
   logic              redirect;
   logic [ADDR_W-1:0] redirect_pc;
   logic              halt_req;
   logic              resume;
   logic              halted;
`ifdef IFETCH_DEBUG_PORT_EN
   logic              dbg_req;
   logic [ADDR_W-1:0] dbg_addr;
   logic              dbg_ack;
   logic [DATA_W-1:0] dbg_data;

   modport master (
      output rom_addr, if_valid, if_instr, if_pc, halted, dbg_ack, dbg_data,
      input  rom_data, if_ready, redirect, redirect_pc, halt_req, resume,
             dbg_req, dbg_addr
   );
   modport slave (
      input  rom_addr, if_valid, if_instr, if_pc, halted, dbg_ack, dbg_data,
      output rom_data, if_ready, redirect, redirect_pc, halt_req, resume,
             dbg_req, dbg_addr
   );
`else
   modport master (
      output rom_addr, if_valid, if_instr, if_pc, halted,
      input  rom_data, if_ready, redirect, redirect_pc, halt_req, resume
   );
   modport slave (
      input  rom_addr, if_valid, if_instr, if_pc, halted,
      output rom_data, if_ready, redirect, redirect_pc, halt_req, resume
   );
`endif

endinterface

// File: rtl/ifetch_queue.sv
// Two-entry {pc, instr} FIFO; slot0 is always the head. Flush beats push/pop.
module ifetch_queue
   import cpu_pkg::*;
#(
   parameter int ADDR_W = CPU_ADDR_W,
   parameter int DATA_W = CPU_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic              pop,
   input  logic              flush,
   input  logic [ADDR_W-1:0] push_pc,
   input  logic [DATA_W-1:0] push_instr,
   output logic [1:0]        count,
   output logic [ADDR_W-1:0] head_pc,
   output logic [DATA_W-1:0] head_instr
);

   logic [ADDR_W-1:0] slot_pc    [2];
   logic [DATA_W-1:0] slot_instr [2];

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         count <= 2'd0;
      end else begin
         count <= count + {1'b0, push} - {1'b0, pop};
      end
   end

   // Payload is not reset; the head is masked to zero whenever count is zero.
   always_ff @(posedge clk) begin
      if (!flush) begin
         if (push && !pop) begin
            if (count == 2'd0) begin
               slot_pc[0]    <= push_pc;
               slot_instr[0] <= push_instr;
            end else begin
               slot_pc[1]    <= push_pc;
               slot_instr[1] <= push_instr;
            end
         end else if (pop && !push) begin
            slot_pc[0]    <= slot_pc[1];
            slot_instr[0] <= slot_instr[1];
         end else if (pop && push) begin
            if (count == 2'd1) begin
               slot_pc[0]    <= push_pc;
               slot_instr[0] <= push_instr;
            end else begin
               slot_pc[0]    <= slot_pc[1];
               slot_instr[0] <= slot_instr[1];
               slot_pc[1]    <= push_pc;
               slot_instr[1] <= push_instr;
            end
         end
      end
   end

   assign head_pc    = (count != 2'd0) ? slot_pc[0]    : '0;
   assign head_instr = (count != 2'd0) ? slot_instr[0] : '0;

endmodule

// File: rtl/ifetch_ctrl.sv
// Instruction-fetch controller: PC, RUN/HALT FSM, ROM address mux and 2-deep queue.
// Define IFETCH_DEBUG_PORT_EN to add the debug ROM read port.
module ifetch_ctrl
   import cpu_pkg::*;
#(
   parameter int              ADDR_W   = CPU_ADDR_W,
   parameter int              DATA_W   = CPU_DATA_W,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(CPU_RESET_PC)
) (
   input logic            clk,
   input logic            rst,
   ifetch_ctrl_if.master  bus
);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] pc_q;
   logic              fetch;
   logic              pop;
   logic              dbg_req_w;
   logic [1:0]        count;
   logic [ADDR_W-1:0] head_pc;
   logic [DATA_W-1:0] head_instr;

   assign pop = bus.if_valid && bus.if_ready;

`ifdef IFETCH_DEBUG_PORT_EN
   logic              dbg_ack_q;
   logic [DATA_W-1:0] dbg_data_q;

   assign dbg_req_w    = bus.dbg_req;
   assign bus.rom_addr = dbg_req_w ? bus.dbg_addr : pc_q;
   assign bus.dbg_ack  = dbg_ack_q;
   assign bus.dbg_data = dbg_data_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         dbg_ack_q  <= 1'b0;
         dbg_data_q <= '0;
      end else begin
         dbg_ack_q <= dbg_req_w;
         if (dbg_req_w) begin
            dbg_data_q <= bus.rom_data;
         end
      end
   end
`else
   assign dbg_req_w    = 1'b0;
   assign bus.rom_addr = pc_q;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RUN;
      end else begin
         state_q <= state_d;
      end
   end

   // A slot frees up this cycle if decode pops, so fetch can refill it immediately.
   always_comb begin
      state_d = state_q;
      fetch   = 1'b0;
      case (state_q)
         RUN: begin
            if (bus.halt_req) begin
               state_d = HALT;
            end
            fetch = !bus.redirect && !dbg_req_w && ((count != 2'd2) || pop);
         end
         HALT: begin
            if (bus.resume && !bus.halt_req) begin
               state_d = RUN;
            end
         end
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q <= RESET_PC;
      end else if (bus.redirect) begin
         pc_q <= bus.redirect_pc;
      end else if (fetch) begin
         pc_q <= pc_q + ADDR_W'(1);
      end
   end

   ifetch_queue #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_queue (
      .clk        (clk),
      .rst        (rst),
      .push       (fetch),
      .pop        (pop),
      .flush      (bus.redirect),
      .push_pc    (pc_q),
      .push_instr (bus.rom_data),
      .count      (count),
      .head_pc    (head_pc),
      .head_instr (head_instr)
   );

   assign bus.if_valid = (count != 2'd0);
   assign bus.if_pc    = head_pc;
   assign bus.if_instr = head_instr;
   assign bus.halted   = (state_q == HALT);

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Directed bench for ifetch_ctrl: stream, back-pressure, redirect, wrap, halt, debug.
module tb_ifetch_ctrl;
   import cpu_pkg::*;

   localparam int ADDR_W = 6;
   localparam int DATA_W = 32;

   logic clk = 1'b0;
   logic rst;
   int   n_chk  = 0;
   int   n_pass = 0;
   logic [DATA_W-1:0] rom [64];

   ifetch_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   ifetch_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   assign bus.rom_data = rom[bus.rom_addr];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   // Advance one cycle; inputs are driven at +2, outputs checked at +3.
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 64; i++) rom[i] = 32'hf000_0000 + 32'(i);
      rom[0]  = 32'h0800000b;  rom[1]  = 32'h20010005;  rom[2]  = 32'h20020007;
      rom[3]  = 32'h00221820;  rom[4]  = 32'hac030000;  rom[5]  = 32'hac0b000c;
      rom[6]  = 32'h8d2c0008;  rom[7]  = 32'h10000003;  rom[8]  = 32'h20040001;
      rom[9]  = 32'h00842020;  rom[10] = 32'h08000002;  rom[11] = 32'h14000001;
      rom[12] = 32'h00000000;  rom[13] = 32'h0800000d;

      rst = 1'b1;
      bus.if_ready = 1'b0;  bus.redirect = 1'b0;  bus.redirect_pc = '0;
      bus.halt_req = 1'b0;  bus.resume = 1'b0;
`ifdef IFETCH_DEBUG_PORT_EN
      bus.dbg_req = 1'b0;   bus.dbg_addr = '0;
`endif
      repeat (3) step();
      #1;
      chk("rst_valid",  64'(bus.if_valid), 64'd0);
      chk("rst_instr",  64'(bus.if_instr), 64'd0);
      chk("rst_pc",     64'(bus.if_pc),    64'd0);
      chk("rst_halted", 64'(bus.halted),   64'd0);
      chk("rst_addr",   64'(bus.rom_addr), 64'd0);

      // Stream: first fetch in the first cycle out of reset, valid one cycle later.
      rst = 1'b0;  bus.if_ready = 1'b1;
      #1;
      chk("first_valid", 64'(bus.if_valid), 64'd0);
      for (int i = 0; i < 14; i++) begin
         step(); #1;
         chk("stream_valid", 64'(bus.if_valid), 64'd1);
         chk("stream_pc",    64'(bus.if_pc),    64'(i));
         chk("stream_instr", 64'(bus.if_instr), 64'(rom[i]));
      end
      chk("word0", 64'(rom[0]), 64'h0800000b);

      // Back-pressure: restart at 0 with decode stalled.
      bus.redirect = 1'b1;  bus.redirect_pc = 6'd0;  bus.if_ready = 1'b0;
      step();
      bus.redirect = 1'b0;
      repeat (5) step();
      #1;
      chk("bp_count", 64'(dut.u_queue.count), 64'd2);
      chk("bp_pc",    64'(bus.rom_addr),      64'd2);
      step(); #1;
      chk("bp_pc_hold", 64'(bus.rom_addr),    64'd2);
      bus.if_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (i != 0) step();
         #1;
         chk("bp_valid", 64'(bus.if_valid), 64'd1);
         chk("bp_pc",    64'(bus.if_pc),    64'(i));
      end

      // Redirect while full and popping.
      chk("rd_full", 64'(dut.u_queue.count), 64'd2);
      bus.redirect = 1'b1;  bus.redirect_pc = 6'd11;
      step();
      bus.redirect = 1'b0;
      #1;
      chk("rd_bubble", 64'(bus.if_valid), 64'd0);
      chk("rd_addr",   64'(bus.rom_addr), 64'd11);
      step(); #1;
      chk("rd_valid", 64'(bus.if_valid), 64'd1);
      chk("rd_pc",    64'(bus.if_pc),    64'd11);
      chk("rd_instr", 64'(bus.if_instr), 64'h14000001);

      // Wrap 63 -> 0.
      bus.redirect = 1'b1;  bus.redirect_pc = 6'd63;
      step();
      bus.redirect = 1'b0;
      #1;
      chk("wrap_bubble", 64'(bus.if_valid), 64'd0);
      step(); #1;
      chk("wrap_pc63",   64'(bus.if_pc),    64'd63);
      chk("wrap_instr",  64'(bus.if_instr), 64'(rom[63]));
      step(); #1;
      chk("wrap_pc0",    64'(bus.if_pc),    64'd0);

      // Halt while streaming: one entry left to drain, then nothing.
      bus.halt_req = 1'b1;
      #1;
      chk("h_not_yet", 64'(bus.halted), 64'd0);
      step();
      bus.halt_req = 1'b0;
      #1;
      chk("h_halted", 64'(bus.halted),   64'd1);
      chk("h_drain",  64'(bus.if_pc),    64'd1);
      chk("h_dvalid", 64'(bus.if_valid), 64'd1);
      step(); #1;
      chk("h_empty",  64'(bus.if_valid), 64'd0);
      chk("h_pchold", 64'(bus.rom_addr), 64'd2);
      bus.redirect = 1'b1;  bus.redirect_pc = 6'd5;
      step();
      bus.redirect = 1'b0;
      #1;
      chk("h_rd_halted", 64'(bus.halted),   64'd1);
      chk("h_rd_valid",  64'(bus.if_valid), 64'd0);
      chk("h_rd_addr",   64'(bus.rom_addr), 64'd5);
      step(); #1;
      chk("h_rd_still", 64'(bus.if_valid), 64'd0);
      bus.resume = 1'b1;
      step();
      bus.resume = 1'b0;
      #1;
      chk("res_halted", 64'(bus.halted),   64'd0);
      chk("res_bubble", 64'(bus.if_valid), 64'd0);
      step(); #1;
      chk("res_pc",    64'(bus.if_pc),    64'd5);
      chk("res_instr", 64'(bus.if_instr), 64'hac0b000c);

      // halt_req beats a simultaneous resume.
      bus.halt_req = 1'b1;  bus.resume = 1'b1;
      step(); #1;
      chk("hr_halt", 64'(bus.halted), 64'd1);
      step(); #1;
      chk("hr_stay", 64'(bus.halted), 64'd1);
      bus.halt_req = 1'b0;
      step();
      bus.resume = 1'b0;
      #1;
      chk("hr_resume", 64'(bus.halted), 64'd0);

      // Reset during halt and redirect.
      bus.halt_req = 1'b1;
      step();
      bus.halt_req = 1'b0;  rst = 1'b1;
      bus.redirect = 1'b1;  bus.redirect_pc = 6'd9;
      step();
      bus.redirect = 1'b0;
      #1;
      chk("mr_halted", 64'(bus.halted),   64'd0);
      chk("mr_valid",  64'(bus.if_valid), 64'd0);
      chk("mr_addr",   64'(bus.rom_addr), 64'd0);
      chk("mr_instr",  64'(bus.if_instr), 64'd0);

`ifdef IFETCH_DEBUG_PORT_EN
      chk("dbg_rst_ack",  64'(bus.dbg_ack),  64'd0);
      chk("dbg_rst_data", 64'(bus.dbg_data), 64'd0);
      rst = 1'b0;
      step(); #1;
      chk("dbg_s0", 64'(bus.if_pc), 64'd0);
      step();
      bus.dbg_req = 1'b1;  bus.dbg_addr = 6'd6;
      #1;
      chk("dbg_s1",   64'(bus.if_pc),    64'd1);
      chk("dbg_addr", 64'(bus.rom_addr), 64'd6);
      step();
      bus.dbg_req = 1'b0;
      #1;
      chk("dbg_ack",   64'(bus.dbg_ack),  64'd1);
      chk("dbg_data",  64'(bus.dbg_data), 64'h8d2c0008);
      chk("dbg_pc",    64'(bus.rom_addr), 64'd2);
      step(); #1;
      chk("dbg_ack_lo", 64'(bus.dbg_ack), 64'd0);
      chk("dbg_s2",     64'(bus.if_pc),   64'd2);
      step(); #1;
      chk("dbg_s3",     64'(bus.if_pc),   64'd3);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
